// File: rtl/decimal_entry.sv
// decimal_entry: turns debounced keypad-style decimal keying into a 32-bit
// binary value (acc = acc*10 + digit via a 3-cycle shift-add sequence).
// Ports: CLOCK_50/RST_N (sync, active-low); digit_in[3:0], digit_key,
//   enter_key, clear_key (async inputs); entry_value, digit_count (live
//   entry); value_out/value_valid (commit); busy, overflow, bad_digit.
module decimal_entry #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned MAX_DIGITS      = 9
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic [3:0]  digit_in,
  input  logic        digit_key,
  input  logic        enter_key,
  input  logic        clear_key,
  output logic [31:0] entry_value,
  output logic [3:0]  digit_count,
  output logic [31:0] value_out,
  output logic        value_valid,
  output logic        busy,
  output logic        overflow,
  output logic        bad_digit
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  // key index: 0 = digit, 1 = enter, 2 = clear
  localparam int K_DIG = 0;
  localparam int K_ENT = 1;
  localparam int K_CLR = 2;

  typedef enum logic [1:0] {IDLE, MUL8, ADD2, ADDD} state_t;

  logic [3:0]       dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d;
  logic [2:0]       key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [2:0]       deb_q, deb_d;
  logic [2:0]       evt_q, evt_d;
  logic [2:0][15:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      temp_q, temp_d;
  logic [31:0]      value_q, value_d;
  logic [3:0]       digit_q, digit_d;
  logic [3:0]       count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             bad_q, bad_d;

  always_comb begin
    // input conditioning
    dig_s1_d = digit_in;
    dig_s2_d = dig_s1_q;
    key_s1_d = {clear_key, enter_key, digit_key};
    key_s2_d = key_s1_q;
    deb_d    = deb_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (key_s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] + 16'd1 == DEBOUNCE_CYCLES) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
    // registered so each press yields exactly one pulse, aligned with the
    // debounced level going high
    evt_d = deb_d & ~deb_q;

    // FSM / datapath defaults
    state_d = state_q;
    acc_d   = acc_q;
    temp_d  = temp_q;
    value_d = value_q;
    digit_d = digit_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    bad_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (evt_q[K_CLR]) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (evt_q[K_ENT]) begin
          value_d = acc_q;
          valid_d = 1'b1;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (evt_q[K_DIG]) begin
          if (dig_s2_q > 4'd9) begin
            bad_d = 1'b1;
          end else if (count_q == MAX_CNT) begin
            ovf_d = 1'b1;
          end else begin
            digit_d = dig_s2_q;
            state_d = MUL8;
          end
        end
      end
      MUL8: begin
        temp_d  = acc_q << 3;
        state_d = ADD2;
      end
      ADD2: begin
        temp_d  = temp_q + (acc_q << 1);
        state_d = ADDD;
      end
      ADDD: begin
        acc_d   = temp_q + {28'd0, digit_q};
        count_d = count_q + 4'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      dig_s1_q <= '0;
      dig_s2_q <= '0;
      key_s1_q <= '0;
      key_s2_q <= '0;
      deb_q    <= '0;
      evt_q    <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      acc_q    <= '0;
      temp_q   <= '0;
      value_q  <= '0;
      digit_q  <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      dig_s1_q <= dig_s1_d;
      dig_s2_q <= dig_s2_d;
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      deb_q    <= deb_d;
      evt_q    <= evt_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      acc_q    <= acc_d;
      temp_q   <= temp_d;
      value_q  <= value_d;
      digit_q  <= digit_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      bad_q    <= bad_d;
    end
  end

  assign entry_value = acc_q;
  assign digit_count = count_q;
  assign value_out   = value_q;
  assign value_valid = valid_q;
  assign busy        = (state_q != IDLE);
  assign overflow    = ovf_q;
  assign bad_digit   = bad_q;

endmodule

// File: tb/tb_decimal_entry.sv
// Bench for decimal_entry: directed scenarios with literal expectations, then
// randomized keying, all compared every cycle against a behavioural model.
module tb_decimal_entry;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic        digit_key = 1'b0;
  logic        enter_key = 1'b0;
  logic        clear_key = 1'b0;
  logic [31:0] entry_value;
  logic [3:0]  digit_count;
  logic [31:0] value_out;
  logic        value_valid;
  logic        busy;
  logic        overflow;
  logic        bad_digit;

  decimal_entry #(.DEBOUNCE_CYCLES(16'd4), .MAX_DIGITS(9)) dut (
    .CLOCK_50   (clk),
    .RST_N      (RST_N),
    .digit_in   (digit_in),
    .digit_key  (digit_key),
    .enter_key  (enter_key),
    .clear_key  (clear_key),
    .entry_value(entry_value),
    .digit_count(digit_count),
    .value_out  (value_out),
    .value_valid(value_valid),
    .busy       (busy),
    .overflow   (overflow),
    .bad_digit  (bad_digit)
  );

  always #10 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_valid = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Keys: delayed two samples, then a level only flips after DEB consecutive
  // disagreeing samples; a press is the debounced level rising.
  // Accepting a digit makes the block busy for 3 cycles; the new value
  // acc*10+digit appears when the busy period ends.
  bit          started = 0;
  logic [2:0]  m_s1, m_s2, m_deb, m_evt;
  int          m_run [3];
  logic [3:0]  m_d1, m_d2;
  logic [31:0] m_acc, m_val;
  int          m_cnt, m_busy, m_pend;
  bit          m_valid, m_ovf, m_bad;

  always @(posedge clk) begin
    logic [2:0] new_evt;
    if (!RST_N) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_evt = 0;
      for (int k = 0; k < 3; k++) m_run[k] = 0;
      m_d1 = 0; m_d2 = 0; m_acc = 0; m_val = 0;
      m_cnt = 0; m_busy = 0; m_pend = 0;
      m_valid = 0; m_ovf = 0; m_bad = 0;
    end else begin
      m_valid = 0;
      m_bad   = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_acc = m_acc * 10 + m_pend;
          m_cnt++;
        end
      end else if (m_evt[2]) begin
        m_acc = 0; m_cnt = 0; m_ovf = 0;
      end else if (m_evt[1]) begin
        m_val = m_acc; m_valid = 1;
        m_acc = 0; m_cnt = 0; m_ovf = 0;
      end else if (m_evt[0]) begin
        if (m_d2 > 9) m_bad = 1;
        else if (m_cnt == 9) m_ovf = 1;
        else begin
          m_pend = int'(m_d2);
          m_busy = 3;
        end
      end
      new_evt = 0;
      for (int k = 0; k < 3; k++) begin
        if (m_s2[k] != m_deb[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin
            m_deb[k] = m_s2[k];
            m_run[k] = 0;
            new_evt[k] = m_deb[k];
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_evt = new_evt;
      m_s2  = m_s1;
      m_s1  = {clear_key, enter_key, digit_key};
      m_d2  = m_d1;
      m_d1  = digit_in;
    end
    started = 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      check("entry_value", entry_value, m_acc);
      check("digit_count", {28'd0, digit_count}, 32'(m_cnt));
      check("value_out", value_out, m_val);
      check("value_valid", {31'd0, value_valid}, {31'd0, m_valid});
      check("busy", {31'd0, busy}, {31'd0, (m_busy != 0)});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("bad_digit", {31'd0, bad_digit}, {31'd0, m_bad});
      if (value_valid === 1'b1) n_valid++;
      if (bad_digit === 1'b1) n_bad++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [2:0] keys, input logic [3:0] d,
                       input int pre, input int hi, input int lo);
    digit_in = d;
    repeat (pre) @(negedge clk);
    {clear_key, enter_key, digit_key} = keys;
    repeat (hi) @(negedge clk);
    {clear_key, enter_key, digit_key} = 3'b000;
    repeat (lo) @(negedge clk);
  endtask

  task automatic key_digit(input logic [3:0] d);
    press(3'b001, d, 3, 10, 12);
  endtask

  initial begin
    int v0, b0;
    bit seen;
    logic [2:0] keys;
    logic [3:0] d;

    // reset
    repeat (3) @(negedge clk);
    check("rst entry_value", entry_value, 32'd0);
    check("rst value_out", value_out, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst flags", {29'd0, value_valid, overflow, bad_digit}, 32'd0);
    RST_N = 1'b1;
    repeat (4) @(negedge clk);

    // 1, 2, 3, enter
    key_digit(4'd1); check("step 1", entry_value, 32'd1);
    key_digit(4'd2); check("step 12", entry_value, 32'd12);
    key_digit(4'd3); check("step 123", entry_value, 32'd123);
    v0 = n_valid;
    press(3'b010, 4'd0, 3, 10, 12);
    check("commit 123", value_out, 32'd123);
    check("one valid pulse", 32'(n_valid - v0), 32'd1);
    check("entry after enter", entry_value, 32'd0);
    check("count after enter", {28'd0, digit_count}, 32'd0);

    // nine 9s then a 5
    for (int i = 0; i < 9; i++) key_digit(4'd9);
    key_digit(4'd5);
    check("nine 9s", entry_value, 32'd999999999);
    check("overflow set", {31'd0, overflow}, 32'd1);
    check("count at max", {28'd0, digit_count}, 32'd9);
    press(3'b010, 4'd0, 3, 10, 12);
    check("commit max", value_out, 32'd999999999);
    check("overflow cleared", {31'd0, overflow}, 32'd0);

    // bad digit, then clear
    key_digit(4'd4);
    b0 = n_bad;
    key_digit(4'hC);
    check("one bad pulse", 32'(n_bad - b0), 32'd1);
    check("entry after bad", entry_value, 32'd4);
    v0 = n_valid;
    press(3'b100, 4'd0, 3, 10, 12);
    check("entry after clear", entry_value, 32'd0);
    check("value kept on clear", value_out, 32'd999999999);
    check("no pulse on clear", 32'(n_valid - v0), 32'd0);

    // bounce: toggle every 2 cycles, then hold
    digit_in = 4'd7;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      digit_key = 1'b1; repeat (2) @(negedge clk);
      digit_key = 1'b0; repeat (2) @(negedge clk);
    end
    press(3'b001, 4'd7, 0, 10, 12);
    check("bounce one digit", {28'd0, digit_count}, 32'd1);
    check("bounce value", entry_value, 32'd7);
    press(3'b001, 4'd7, 0, 3, 12);
    check("glitch ignored", {28'd0, digit_count}, 32'd1);

    // enter + clear together: clear wins
    v0 = n_valid;
    press(3'b110, 4'd0, 3, 10, 12);
    check("clear wins entry", entry_value, 32'd0);
    check("clear wins no pulse", 32'(n_valid - v0), 32'd0);
    check("clear wins value", value_out, 32'd999999999);

    // reset during ADD2
    key_digit(4'd8);
    digit_in = 4'd3;
    repeat (3) @(negedge clk);
    digit_key = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
    end
    check("busy seen before reset", {31'd0, seen}, 32'd1);
    @(negedge clk);
    RST_N = 1'b0;
    digit_key = 1'b0;
    repeat (2) @(negedge clk);
    RST_N = 1'b1;
    repeat (12) @(negedge clk);
    check("reset mid acc", entry_value, 32'd0);
    check("reset mid busy", {31'd0, busy}, 32'd0);
    check("reset mid count", {28'd0, digit_count}, 32'd0);

    // randomized keying
    for (int i = 0; i < 160; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 65)      keys = 3'b001;
      else if (r < 78) keys = 3'b010;
      else if (r < 88) keys = 3'b100;
      else             keys = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) d = 4'($urandom_range(10, 15));
      else                           d = 4'($urandom_range(0, 9));
      press(keys, d, $urandom_range(0, 3), $urandom_range(1, 12), $urandom_range(1, 14));
    end
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decimal_entry.md
Name: decimal_entry

Overview:
- Converts operator decimal keying into a 32-bit binary value. This is the input-side counterpart of the binary-to-decimal 7-segment display path.
- Digits arrive as a 4-bit BCD code on board switches, qualified by push-button strobes.
- The block accumulates the value as acc = acc*10 + digit, using a multi-cycle shift-add sequence.
- On enter, it publishes the result with a one-cycle valid pulse. The live accumulator feeds the display path so the operator sees the entry while typing.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: number of consecutive stable cycles on a synchronized strobe before its debounced level changes (1 ms at 50 MHz). Must be >=1.
- MAX_DIGITS, 9: maximum digits accepted per entry. 9 guarantees the result is at most 999,999,999 and never exceeds 32 bits.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- RST_N  in  1  synchronous active-low reset
- digit_in  in  4  BCD digit from switches; asynchronous, sampled through a synchronizer
- digit_key  in  1  active-high "accept digit" strobe; asynchronous, bouncy
- enter_key  in  1  active-high "commit value" strobe; asynchronous, bouncy
- clear_key  in  1  active-high "discard entry" strobe; asynchronous, bouncy
- entry_value  out  32  live accumulator, for display
- digit_count  out  4  digits accepted in the current entry
- value_out  out  32  last committed value
- value_valid  out  1  one-cycle pulse when value_out updates
- busy  out  1  high while the multiply-add sequence runs
- overflow  out  1  sticky: a digit was rejected because MAX_DIGITS was reached
- bad_digit  out  1  one-cycle pulse: digit_key event with digit_in > 9

Behaviour:
- Reset (RST_N low at a clock edge):
  - All outputs are 0; accumulator, temp register, digit latch and counters are 0.
  - Synchronizers and debounced levels are 0; FSM goes to IDLE.
  - Reset mid-sequence aborts the sequence with no partial update.
- Input conditioning:
  - Every key and digit_in bit passes through a 2-flop synchronizer.
  - Each key has its own debounce counter. The counter clears whenever the synced level equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - An event is a one-cycle rising edge of the debounced level. Falling edges generate nothing.
- FSM states: IDLE, MUL8, ADD2, ADDD.
- IDLE, event priority when several occur in the same cycle: clear > enter > digit.
  - Clear event: accumulator, digit_count and overflow go to 0. value_out is unchanged and no valid pulse is issued.
  - Enter event: on the next cycle value_out <= accumulator and value_valid = 1 for exactly one cycle. Accumulator, digit_count and overflow clear in the same cycle. Enter with zero digits still commits 0 with a pulse.
  - Digit event:
    - If the synced digit_in > 9: bad_digit pulses for one cycle; there is no other effect.
    - Else if digit_count == MAX_DIGITS: overflow is set and the digit is dropped.
    - Otherwise: the digit is latched, the FSM goes to MUL8 and busy goes to 1.
- MUL8: temp <= acc << 3; go to ADD2.
- ADD2: temp <= temp + (acc << 1); go to ADDD.
- ADDD: acc <= temp + latched digit; digit_count += 1; go to IDLE; busy drops to 0 on the following cycle.
- Digit latency: entry_value reflects the new digit 3 cycles after the event cycle. busy is high for exactly 3 cycles.
- Events occurring while busy = 1 are dropped and not queued. This includes clear and enter. Keys are human-rate, so no loss is expected in practice.
- Arithmetic is unsigned 32-bit. No wrap can occur within MAX_DIGITS <= 9.
- Holding a key produces one event. A new event requires a release, a debounced low, then a new debounced press.

Test Plan:
- Reset with DEBOUNCE_CYCLES=4 and all keys low -> all outputs 0, busy 0.
- Key digits 1, 2, 3, then enter -> entry_value steps 1, 12, 123. Each update lands 3 cycles after its event. value_out=123 with a single value_valid pulse; entry_value and digit_count then return to 0.
- Key 9 digits of 9, then a 10th digit of 5 -> entry_value=999999999 and overflow=1. Enter -> value_out=999999999 and overflow clears.
- Key 4, then digit_in=4'hC with digit_key -> one bad_digit pulse; entry_value stays 4. Clear -> entry_value 0, value_out unchanged.
- Bounce: digit_key toggles every 2 cycles for 20 cycles, then holds high -> exactly one digit accepted. A glitch shorter than 4 cycles -> no event.
- Enter and clear debounced in the same cycle -> clear wins, no valid pulse. Reset asserted during ADD2 -> accumulator stays 0, FSM in IDLE.
